game_pulse_ctrl: RTL
====================

GAME_PULSE_CTRL -- requirements
Module: game_pulse_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, width of score and time_left.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a button level (>=1).
REQ-003 Parameter ROUND_TICKS, default 200, time_left load value at round start (1..2^WIDTH-1).
REQ-004 clock  input  1  single clock, all flops on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; asserted low clears all state immediately.
REQ-006 start  input  1  level; requests a round from IDLE or OVER.
REQ-007 tick  input  1  single-cycle time-base strobe.
REQ-008 btn_up  input  1  raw asynchronous button, active-high.
REQ-009 btn_down  input  1  raw asynchronous button, active-high.
REQ-010 score  input  WIDTH  current value read back from the score counters.
REQ-011 increase  output  1  registered single-cycle pulse to the up-counter.
REQ-012 decrease  output  1  registered single-cycle pulse to the down-counter.
REQ-013 game_state  output  2  IDLE=0, PLAY=1, OVER=2; 3 unused.
REQ-014 time_left  output  WIDTH  registered remaining ticks.
REQ-015 round_over  output  1  high exactly while game_state==OVER.

Function
REQ-016 FSM IDLE: start=1 at an edge -> PLAY, time_left loaded ROUND_TICKS on that edge.
REQ-017 FSM PLAY: tick=1 decrements time_left by 1; tick=1 with time_left==1 -> time_left=0 and game_state=OVER on the same edge.
REQ-018 FSM OVER: time_left holds 0; start=1 -> PLAY with time_left reloaded ROUND_TICKS.
REQ-019 start in PLAY ignored; tick outside PLAY ignored; time_left never wraps below 0.
REQ-020 Each button: 2-flop synchronizer, then debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from current debounced level.
REQ-021 Rising edge of debounced up level produces one candidate up pulse; falling edges, held levels produce nothing; same for down.
REQ-022 Latency: btn held high from edge E (first sampling high) -> increase high in the cycle after edge E+DEBOUNCE_CYCLES+2, for one cycle only.
REQ-023 Glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no pulse.
REQ-024 increase/decrease asserted only in cycles where game_state reads PLAY; candidates arising at the edge entering OVER or while IDLE/OVER are dropped, not queued.
REQ-025 Saturation: candidate up dropped when score==2^WIDTH-1; candidate down dropped when score==0; score sampled at the candidate edge.
REQ-026 Up and down candidates on the same edge: both dropped (net zero).
REQ-027 increase and decrease never high in the same cycle.

Reset
REQ-028 reset low: game_state=IDLE, time_left=0, increase=0, decrease=0, round_over=0, synchronizers and debounced levels 0, debounce counters 0.
REQ-029 Reset mid-round aborts immediately; after release, button held high is treated as a new press (full debounce latency).
REQ-030 Release of reset takes effect on the first rising clock edge with reset high; no output changes before it.

Structure
REQ-031 Shared package game_pkg holds game_state encodings (IDLE, PLAY, OVER) and the 2-bit state width constant.
REQ-032 One sub-module button_debounce (synchronizer + debouncer + rising-edge detect, param DEBOUNCE_CYCLES), instantiated twice.
REQ-033 FSM, timer and pulse gating live in game_pulse_ctrl; total RTL 120-400 lines.

Verification (bench: WIDTH=8, DEBOUNCE_CYCLES=4, ROUND_TICKS=10)
REQ-034 reset low, start=1, btn_up=1 -> game_state=0, time_left=0, increase=0 throughout; after release, start=1 one cycle -> game_state=1, time_left=10.
REQ-035 In PLAY, score=5, btn_up high from edge E for 20 cycles -> exactly one increase pulse, in the cycle after edge E+6; no decrease.
REQ-036 In PLAY, btn_down 3-cycle glitch -> no pulse; score=0 with valid down press -> no pulse; score=255 with valid up press -> no pulse.
REQ-037 btn_up and btn_down rise on the same edge, both held -> neither pulse.
REQ-038 10 tick strobes in PLAY -> time_left 10..0, game_state=2, round_over=1 on the 10th tick edge; press completing in OVER -> no pulse; start=1 -> PLAY, time_left=10.
REQ-039 reset pulsed low mid-round with time_left=4 and btn_up held -> immediate IDLE, time_left=0; after restart, btn_up still held -> one increase after full 6-edge latency.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings for the game pulse controller: round-state values and width.
package game_pkg;

  localparam int STATE_W = 2;

  // Round states as seen on game_state_o; encoding 3 is never produced.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

endpackage

// File: rtl/button_debounce.sv
// Raw asynchronous button -> 2-flop synchronizer -> debouncer -> rising-edge strobe.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples all disagree with it; rise_o is high for the one cycle after it flips to 1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          level_prev_q;
  logic [CW-1:0] cnt_q;

  // Two-stage synchronizer; sync_q[1] is the safe sampled level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      level_prev_q <= level_q;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/game_pulse_ctrl.sv
// Round controller: IDLE/PLAY/OVER state machine, tick-driven round timer and
// gating of debounced button presses into single-cycle increase/decrease pulses.
module game_pulse_ctrl
  import game_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROUND_TICKS     = 200
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             tick_i,
  input  logic             btn_up_i,
  input  logic             btn_down_i,
  input  logic [WIDTH-1:0] score_i,
  output logic             increase_o,
  output logic             decrease_o,
  output logic [1:0]       game_state_o,
  output logic [WIDTH-1:0] time_left_o,
  output logic             round_over_o
);

  localparam logic [WIDTH-1:0] LOAD      = WIDTH'(ROUND_TICKS);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] SCORE_MAX = {WIDTH{1'b1}};

  game_state_e      state_q;
  logic [WIDTH-1:0] time_left_q;
  logic             increase_q;
  logic             decrease_q;

  logic up_rise;
  logic down_rise;
  logic stays_in_play;
  logic up_ok;
  logic down_ok;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_up_i),
    .rise_o (up_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down_db (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (btn_down_i),
    .rise_o (down_rise)
  );

  // A pulse may only go out if the machine is in PLAY now and still in PLAY after
  // this edge, so presses landing on the final tick are dropped rather than queued.
  assign stays_in_play = (state_q == ST_PLAY) && !(tick_i && (time_left_q == ONE));
  // Simultaneous up/down presses cancel; saturated score blocks its direction.
  assign up_ok   = up_rise && !down_rise && (score_i != SCORE_MAX);
  assign down_ok = down_rise && !up_rise && (score_i != '0);

  // Round FSM, timer and registered pulse outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      time_left_q <= '0;
      increase_q  <= 1'b0;
      decrease_q  <= 1'b0;
    end else begin
      increase_q <= stays_in_play && up_ok;
      decrease_q <= stays_in_play && down_ok;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_i) begin
            state_q     <= ST_PLAY;
            time_left_q <= LOAD;
          end
        end
        ST_PLAY: begin
          if (tick_i && (time_left_q != '0)) begin
            time_left_q <= time_left_q - ONE;
            if (time_left_q == ONE) begin
              state_q <= ST_OVER;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          time_left_q <= '0;
        end
      endcase
    end
  end

  assign increase_o   = increase_q;
  assign decrease_o   = decrease_q;
  assign game_state_o = state_q;
  assign time_left_o  = time_left_q;
  assign round_over_o = (state_q == ST_OVER);

endmodule
